// File: rtl/switch_allocator.sv
// Round-robin switch allocator with per-output wormhole locking, downstream
// credit counters and a registered crossbar select for switch traversal.
module switch_allocator #(
   parameter int N_PORTS      = 5,
   parameter int BUFFER_DEPTH = 4,
   parameter int CREDIT_W     = $clog2(BUFFER_DEPTH + 1),
   parameter int SEL_W        = $clog2(N_PORTS)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [N_PORTS-1:0]              valid_i,
   input  logic [N_PORTS-1:0]              head_i,
   input  logic [N_PORTS-1:0]              tail_i,
   input  logic [N_PORTS-1:0][SEL_W-1:0]   out_Port_i,
   input  logic [N_PORTS-1:0]              credit_Ret_i,
   output logic [N_PORTS-1:0]              grant_o,
   output logic [N_PORTS-1:0][SEL_W-1:0]   xbar_Sel_o,
   output logic [N_PORTS-1:0]              xbar_Valid_o
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                state  [N_PORTS];
   logic [SEL_W-1:0]      owner  [N_PORTS];
   logic [SEL_W-1:0]      rr_ptr [N_PORTS];
   logic [CREDIT_W-1:0]   cnt    [N_PORTS];

   logic [N_PORTS-1:0]            out_grant;
   logic [N_PORTS-1:0][SEL_W-1:0] out_win;
   int                            scan_idx;

   // Scanning from the far end down to rr_ptr lets the last hit win, which is
   // the first candidate at or after the pointer in circular order.
   always_comb begin
      out_grant = '0;
      out_win   = '0;
      scan_idx  = 0;
      for (int o = 0; o < N_PORTS; o++) begin
         if (state[o] == LOCKED) begin
            out_win[o]   = owner[o];
            out_grant[o] = valid_i[owner[o]] && (cnt[o] != '0);
         end else if (cnt[o] != '0) begin
            for (int k = N_PORTS - 1; k >= 0; k--) begin
               scan_idx = (int'(rr_ptr[o]) + k) % N_PORTS;
               if (valid_i[scan_idx] && head_i[scan_idx] &&
                   (out_Port_i[scan_idx] == SEL_W'(o))) begin
                  out_grant[o] = 1'b1;
                  out_win[o]   = SEL_W'(scan_idx);
               end
            end
         end
      end
   end

   always_comb begin
      grant_o = '0;
      for (int o = 0; o < N_PORTS; o++) begin
         if (out_grant[o]) begin
            grant_o[out_win[o]] = 1'b1;
         end
      end
      if (!rst_n) begin
         grant_o = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int o = 0; o < N_PORTS; o++) begin
            state[o]  <= IDLE;
            owner[o]  <= '0;
            rr_ptr[o] <= '0;
            cnt[o]    <= CREDIT_W'(BUFFER_DEPTH);
         end
         xbar_Valid_o <= '0;
         xbar_Sel_o   <= '0;
      end else begin
         for (int o = 0; o < N_PORTS; o++) begin
            xbar_Valid_o[o] <= out_grant[o];
            if (out_grant[o]) begin
               xbar_Sel_o[o] <= out_win[o];
               if (state[o] == IDLE) begin
                  rr_ptr[o] <= (out_win[o] == SEL_W'(N_PORTS - 1)) ? '0 : out_win[o] + SEL_W'(1);
                  if (!tail_i[out_win[o]]) begin
                     state[o] <= LOCKED;
                     owner[o] <= out_win[o];
                  end
               end else if (tail_i[out_win[o]]) begin
                  state[o] <= IDLE;
               end
            end
            // A grant and a return in the same cycle cancel; excess returns are dropped.
            if (out_grant[o] && !credit_Ret_i[o]) begin
               cnt[o] <= cnt[o] - CREDIT_W'(1);
            end else if (!out_grant[o] && credit_Ret_i[o] &&
                         (cnt[o] < CREDIT_W'(BUFFER_DEPTH))) begin
               cnt[o] <= cnt[o] + CREDIT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_switch_allocator.sv
// Scoreboard bench for switch_allocator: directed per-cycle vectors push
// hand-computed expectations, a negedge monitor pops and compares them.
module tb_switch_allocator;

   localparam int N_PORTS = 5;
   localparam int SEL_W   = 3;
   localparam int LOCAL = 0, NORTH = 1, SOUTH = 2, WEST = 3, EAST = 4;

   logic                          clk;
   logic                          rst_n;
   logic [N_PORTS-1:0]            valid_i, head_i, tail_i, credit_Ret_i;
   logic [N_PORTS-1:0][SEL_W-1:0] out_Port_i;
   logic [N_PORTS-1:0]            grant_o, xbar_Valid_o;
   logic [N_PORTS-1:0][SEL_W-1:0] xbar_Sel_o;

   typedef struct packed {
      logic [N_PORTS-1:0]            grant;
      logic [N_PORTS-1:0]            xv;
      logic [SEL_W-1:0]              xs;
      logic [N_PORTS-1:0]            xs_mask;
      logic [15:0]                   row;
   } exp_t;

   exp_t exp_q[$];
   int   check_cnt = 0;
   int   pass_cnt  = 0;
   int   row_cnt   = 0;

   switch_allocator #(.N_PORTS(5), .BUFFER_DEPTH(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .valid_i      (valid_i),
      .head_i       (head_i),
      .tail_i       (tail_i),
      .out_Port_i   (out_Port_i),
      .credit_Ret_i (credit_Ret_i),
      .grant_o      (grant_o),
      .xbar_Sel_o   (xbar_Sel_o),
      .xbar_Valid_o (xbar_Valid_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [N_PORTS-1:0][SEL_W-1:0] allPorts(input int dir);
      logic [N_PORTS-1:0][SEL_W-1:0] p;
      for (int i = 0; i < N_PORTS; i++) p[i] = SEL_W'(dir);
      return p;
   endfunction

   // Drives one cycle of inputs just after the rising edge and queues the
   // response the DUT must show during that cycle.
   task automatic applyStimulus(input logic r, input logic [4:0] v, input logic [4:0] h,
                                input logic [4:0] t, input int dir, input logic [4:0] cr,
                                input logic [4:0] eg, input logic [4:0] exv,
                                input int esel, input logic [4:0] smask);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n        = r;
      valid_i      = v;
      head_i       = h;
      tail_i       = t;
      out_Port_i   = allPorts(dir);
      credit_Ret_i = cr;
      e.grant   = eg;
      e.xv      = exv;
      e.xs      = SEL_W'(esel);
      e.xs_mask = smask;
      e.row     = 16'(row_cnt);
      row_cnt++;
      exp_q.push_back(e);
   endtask

   task automatic checkOutput(input exp_t e);
      check_cnt++;
      if (grant_o === e.grant) pass_cnt++;
      else $display("[TB] FAIL grant row %0d: got %b expected %b", e.row, grant_o, e.grant);
      check_cnt++;
      if (xbar_Valid_o === e.xv) pass_cnt++;
      else $display("[TB] FAIL xbar_valid row %0d: got %b expected %b", e.row, xbar_Valid_o, e.xv);
      for (int o = 0; o < N_PORTS; o++) begin
         if (e.xs_mask[o]) begin
            check_cnt++;
            if (xbar_Sel_o[o] === e.xs) pass_cnt++;
            else $display("[TB] FAIL xbar_sel[%0d] row %0d: got %0d expected %0d",
                          o, e.row, xbar_Sel_o[o], e.xs);
         end
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         checkOutput(exp_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n        = 1'b0;
      valid_i      = '0;
      head_i       = '0;
      tail_i       = '0;
      out_Port_i   = '0;
      credit_Ret_i = '0;

      // Reset: idle outputs, grant suppressed even with a pending request.
      applyStimulus(0, 5'b00000, 5'b00000, 5'b00000, EAST, 5'b00000, 5'b00000, 5'b00000, 0, 5'b11111);
      applyStimulus(0, 5'b00001, 5'b00001, 5'b00001, EAST, 5'b00000, 5'b00000, 5'b00000, 0, 5'b11111);

      // Single-flit LOCAL -> EAST.
      applyStimulus(1, 5'b00001, 5'b00001, 5'b00001, EAST, 5'b00000, 5'b00001, 5'b00000, 0, 5'b00000);
      applyStimulus(1, 5'b00000, 5'b00000, 5'b00000, EAST, 5'b00000, 5'b00000, 5'b10000, 0, 5'b10000);

      // NORTH and WEST 3-flit packets to SOUTH; credits returned every cycle.
      applyStimulus(1, 5'b01010, 5'b01010, 5'b00000, SOUTH, 5'b00100, 5'b00010, 5'b00000, 0, 5'b00000);
      applyStimulus(1, 5'b01010, 5'b01000, 5'b00000, SOUTH, 5'b00100, 5'b00010, 5'b00100, 1, 5'b00100);
      applyStimulus(1, 5'b01010, 5'b01000, 5'b00010, SOUTH, 5'b00100, 5'b00010, 5'b00100, 1, 5'b00100);
      applyStimulus(1, 5'b01000, 5'b01000, 5'b00000, SOUTH, 5'b00100, 5'b01000, 5'b00100, 1, 5'b00100);
      applyStimulus(1, 5'b01000, 5'b00000, 5'b00000, SOUTH, 5'b00100, 5'b01000, 5'b00100, 3, 5'b00100);
      applyStimulus(1, 5'b01000, 5'b00000, 5'b01000, SOUTH, 5'b00100, 5'b01000, 5'b00100, 3, 5'b00100);
      applyStimulus(1, 5'b00000, 5'b00000, 5'b00000, SOUTH, 5'b00000, 5'b00000, 5'b00100, 3, 5'b00100);

      // EAST back to 4 credits, then drain them with no returns.
      applyStimulus(1, 5'b00000, 5'b00000, 5'b00000, EAST, 5'b10000, 5'b00000, 5'b00000, 0, 5'b00000);
      applyStimulus(1, 5'b00001, 5'b00001, 5'b00001, EAST, 5'b00000, 5'b00001, 5'b00000, 0, 5'b00000);
      for (int i = 0; i < 3; i++)
         applyStimulus(1, 5'b00001, 5'b00001, 5'b00001, EAST, 5'b00000, 5'b00001, 5'b10000, 0, 5'b10000);
      applyStimulus(1, 5'b00001, 5'b00001, 5'b00001, EAST, 5'b00000, 5'b00000, 5'b10000, 0, 5'b10000);
      applyStimulus(1, 5'b00001, 5'b00001, 5'b00001, EAST, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000);
      // Return at cnt=0 does not grant in the same cycle; next cycle does.
      applyStimulus(1, 5'b00001, 5'b00001, 5'b00001, EAST, 5'b10000, 5'b00000, 5'b00000, 0, 5'b00000);
      applyStimulus(1, 5'b00001, 5'b00001, 5'b00001, EAST, 5'b00000, 5'b00001, 5'b00000, 0, 5'b00000);
      applyStimulus(1, 5'b00001, 5'b00001, 5'b00001, EAST, 5'b00000, 5'b00000, 5'b10000, 0, 5'b10000);
      // Build cnt to 2, grant+return keeps 2: exactly two more grants follow.
      applyStimulus(1, 5'b00000, 5'b00000, 5'b00000, EAST, 5'b10000, 5'b00000, 5'b00000, 0, 5'b00000);
      applyStimulus(1, 5'b00000, 5'b00000, 5'b00000, EAST, 5'b10000, 5'b00000, 5'b00000, 0, 5'b00000);
      applyStimulus(1, 5'b00001, 5'b00001, 5'b00001, EAST, 5'b10000, 5'b00001, 5'b00000, 0, 5'b00000);
      applyStimulus(1, 5'b00001, 5'b00001, 5'b00001, EAST, 5'b00000, 5'b00001, 5'b10000, 0, 5'b10000);
      applyStimulus(1, 5'b00001, 5'b00001, 5'b00001, EAST, 5'b00000, 5'b00001, 5'b10000, 0, 5'b10000);
      applyStimulus(1, 5'b00001, 5'b00001, 5'b00001, EAST, 5'b00000, 5'b00000, 5'b10000, 0, 5'b10000);
      // Five returns from 0: saturate at 4, so exactly four grants follow.
      for (int i = 0; i < 5; i++)
         applyStimulus(1, 5'b00000, 5'b00000, 5'b00000, EAST, 5'b10000, 5'b00000, 5'b00000, 0, 5'b00000);
      applyStimulus(1, 5'b00001, 5'b00001, 5'b00001, EAST, 5'b00000, 5'b00001, 5'b00000, 0, 5'b00000);
      for (int i = 0; i < 3; i++)
         applyStimulus(1, 5'b00001, 5'b00001, 5'b00001, EAST, 5'b00000, 5'b00001, 5'b10000, 0, 5'b10000);
      applyStimulus(1, 5'b00001, 5'b00001, 5'b00001, EAST, 5'b00000, 5'b00000, 5'b10000, 0, 5'b10000);
      applyStimulus(1, 5'b00000, 5'b00000, 5'b00000, EAST, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000);

      // Reset in the middle of a NORTH -> WEST packet.
      applyStimulus(1, 5'b00010, 5'b00010, 5'b00000, WEST, 5'b00000, 5'b00010, 5'b00000, 0, 5'b00000);
      applyStimulus(1, 5'b00010, 5'b00000, 5'b00000, WEST, 5'b00000, 5'b00010, 5'b01000, 1, 5'b01000);
      applyStimulus(0, 5'b00010, 5'b00000, 5'b00000, WEST, 5'b00000, 5'b00000, 5'b00000, 0, 5'b11111);
      applyStimulus(1, 5'b00011, 5'b00001, 5'b00001, WEST, 5'b00000, 5'b00001, 5'b00000, 0, 5'b00000);
      // EAST credits were restored by the reset.
      applyStimulus(1, 5'b00100, 5'b00100, 5'b00100, EAST, 5'b00000, 5'b00100, 5'b01000, 0, 5'b01000);
      applyStimulus(1, 5'b00000, 5'b00000, 5'b00000, EAST, 5'b00000, 5'b00000, 5'b10000, 2, 5'b10000);

      // All inputs stream single-flit packets to LOCAL with credits kept full.
      applyStimulus(1, 5'b11111, 5'b11111, 5'b11111, LOCAL, 5'b00001, 5'b00001, 5'b00000, 0, 5'b00000);
      for (int i = 1; i < 7; i++)
         applyStimulus(1, 5'b11111, 5'b11111, 5'b11111, LOCAL, 5'b00001,
                       5'(1 << (i % 5)), 5'b00001, (i - 1) % 5, 5'b00001);
      applyStimulus(1, 5'b00000, 5'b00000, 5'b00000, LOCAL, 5'b00000, 5'b00000, 5'b00001, 1, 5'b00001);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         check_cnt++;
         $display("[TB] FAIL drain: got %0d pending expectations expected 0", exp_q.size());
      end
      @(posedge clk);
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
